// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and encodings for the RAM access arbiter: FSM states,
// access size codes and read/write direction.
package ram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Requester slots in the req/gnt vectors.
  localparam int REQ_IF = 0;
  localparam int REQ_DU = 1;

  // The reserved size code 11 is carried onto the RAM bus as a plain word.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rr.sv
// Two-requester round-robin arbiter. Grant is combinational; the pointer
// moves to the requester that lost each granted arbitration.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // r_ptr = 0 favours fetch (req[0]), 1 favours the data unit (req[1]).
  logic r_ptr;

  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shared-RAM sequencer: arbitrates fetch and data-unit MFA/MOC handshakes,
// drives the RAM bus for WAIT_CYCLES+1 cycles and returns registered read data.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_mfa,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_moc,
  output logic [31:0]       if_rdata,
  input  logic              du_mfa,
  input  logic              du_rw,
  input  logic [1:0]        du_size,
  input  logic [ADDR_W-1:0] du_addr,
  input  logic [31:0]       du_wdata,
  output logic              du_moc,
  output logic [31:0]       du_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sel_du;
  logic               r_ram_en;
  logic               r_ram_rw;
  logic [1:0]         r_ram_size;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [31:0]        r_ram_wdata;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_du_rdata;

  logic [1:0]         w_gnt;
  logic               w_grant;
  logic               w_done;
  logic               w_sel_mfa;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({du_mfa, if_mfa}),
    .advance (w_grant),
    .gnt     (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_sel_mfa   = r_sel_du ? du_mfa : if_mfa;
    unique case (r_state)
      IDLE: begin
        if (w_gnt != 2'b00) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        // Only the granted requester's MFA can release the handshake.
        if (!w_sel_mfa) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus fields are captured once at grant, so requester-side changes during
  // ACCESS cannot reach the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_du    <= 1'b0;
      r_cnt       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b0;
      r_ram_size  <= 2'b00;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_grant) begin
      r_sel_du <= w_gnt[REQ_DU];
      r_cnt    <= CNT_LOAD;
      r_ram_en <= 1'b1;
      if (w_gnt[REQ_DU]) begin
        r_ram_rw    <= du_rw;
        r_ram_size  <= norm_size(du_size);
        r_ram_addr  <= du_addr;
        r_ram_wdata <= du_wdata;
      end else begin
        r_ram_rw    <= RW_READ;
        r_ram_size  <= SZ_WORD;
        r_ram_addr  <= if_addr;
        r_ram_wdata <= '0;
      end
    end else if (w_done) begin
      r_ram_en <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Read data lands on the last ram_en cycle; writes leave both registers alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= '0;
      r_du_rdata <= '0;
    end else if (w_done && (r_ram_rw == RW_READ)) begin
      if (r_sel_du) begin
        r_du_rdata <= ram_rdata;
      end else begin
        r_if_rdata <= ram_rdata;
      end
    end
  end

  assign if_moc    = (r_state == ACK) && !r_sel_du;
  assign du_moc    = (r_state == ACK) &&  r_sel_du;
  assign if_rdata  = r_if_rdata;
  assign du_rdata  = r_du_rdata;
  assign ram_en    = r_ram_en;
  assign ram_rw    = r_ram_rw;
  assign ram_size  = r_ram_size;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: drivers push expected accesses,
// a negedge monitor checks bus timing, arbitration order and returned data.
module tb_ram_access_arbiter;

  localparam int         WAIT    = 2;
  localparam logic [7:0] DU_BASE = 8'h20;
  localparam int         TMO     = 200;

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        if_mfa = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic        if_moc;
  logic [31:0] if_rdata;
  logic        du_mfa = 1'b0;
  logic        du_rw = 1'b0;
  logic [1:0]  du_size = 2'b00;
  logic [7:0]  du_addr = 8'h00;
  logic [31:0] du_wdata = 32'h0;
  logic        du_moc;
  logic [31:0] du_rdata;
  logic        ram_en, ram_rw;
  logic [1:0]  ram_size;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic        if0_mfa = 1'b0;
  logic [7:0]  if0_addr = 8'h00;
  logic        if0_moc, du0_moc;
  logic [31:0] if0_rdata, du0_rdata;
  logic        ram0_en, ram0_rw;
  logic [1:0]  ram0_size;
  logic [7:0]  ram0_addr;
  logic [31:0] ram0_wdata, ram0_rdata;

  logic [31:0] ram_mem   [256];
  logic [31:0] model_mem [256];
  exp_t        q_if[$];
  exp_t        q_du[$];
  logic [31:0] du_last_rd = 32'h0;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  ram_access_arbiter #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_mfa(if_mfa), .if_addr(if_addr), .if_moc(if_moc), .if_rdata(if_rdata),
    .du_mfa(du_mfa), .du_rw(du_rw), .du_size(du_size), .du_addr(du_addr),
    .du_wdata(du_wdata), .du_moc(du_moc), .du_rdata(du_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_access_arbiter #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_mfa(if0_mfa), .if_addr(if0_addr), .if_moc(if0_moc), .if_rdata(if0_rdata),
    .du_mfa(1'b0), .du_rw(1'b0), .du_size(2'b00), .du_addr(8'h00),
    .du_wdata(32'h0), .du_moc(du0_moc), .du_rdata(du0_rdata),
    .ram_en(ram0_en), .ram_rw(ram0_rw), .ram_size(ram0_size), .ram_addr(ram0_addr),
    .ram_wdata(ram0_wdata), .ram_rdata(ram0_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz);
    case (sz)
      2'b00:   return {old[31:8], wd[7:0]};
      2'b01:   return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Bench RAM: combinational read, byte/half/word lane write while enabled.
  assign ram_rdata  = ram_mem[ram_addr];
  assign ram0_rdata = {24'hC0FFEE, ram0_addr};
  always @(posedge clk) begin
    if (ram_en && !ram_rw) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_size);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_moc(input bit is_du, input logic level, input string name);
    int n = 0;
    while (((is_du ? du_moc : if_moc) !== level) && n < TMO) begin
      tick();
      n++;
    end
    check(name, 32'(is_du ? du_moc : if_moc), 32'(level));
  endtask

  task automatic do_fetch(input logic [7:0] a);
    exp_t e;
    e = '{addr: a, rw: 1'b1, size: 2'b10, wdata: 32'h0, rdata: model_mem[a]};
    q_if.push_back(e);
    if_addr = a;
    if_mfa  = 1'b1;
    wait_moc(1'b0, 1'b1, "if_moc_rise");
    if_mfa = 1'b0;
    if_addr = 8'hxx;
    wait_moc(1'b0, 1'b0, "if_moc_fall");
  endtask

  task automatic do_data(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] wd, input bit early);
    exp_t e;
    int   n = 0;
    e.addr  = a;
    e.rw    = rw;
    e.size  = (sz == 2'b11) ? 2'b10 : sz;
    e.wdata = wd;
    if (rw) begin
      e.rdata    = model_mem[a];
      du_last_rd = model_mem[a];
    end else begin
      e.rdata      = du_last_rd;
      model_mem[a] = merge(model_mem[a], wd, sz);
    end
    q_du.push_back(e);
    du_rw = rw; du_size = sz; du_addr = a; du_wdata = wd;
    du_mfa = 1'b1;
    if (early) begin
      while (!(ram_en && ram_addr == a && ram_rw == rw) && n < TMO) begin
        tick();
        n++;
      end
      check("du_grant_seen", 32'(ram_en && ram_addr == a), 32'd1);
      // Drop the request mid-access and scramble the fields the RAM must not see.
      du_mfa = 1'b0;
      du_addr = ~a; du_wdata = ~wd;
      wait_moc(1'b1, 1'b1, "du_moc_rise_early");
    end else begin
      wait_moc(1'b1, 1'b1, "du_moc_rise");
      du_mfa = 1'b0;
    end
    wait_moc(1'b1, 1'b0, "du_moc_fall");
  endtask

  // Monitor: reference timing and round-robin order, compared against the
  // expected-access queues whenever a MOC rises.
  logic        en_prev = 1'b0, moc_prev = 1'b0, in_flight = 1'b0;
  logic        rr_ptr = 1'b0, g_du = 1'b0, moc_w, moc_l;
  logic [1:0]  req_prev = 2'b00;
  int          lat = 0, en_len = 0;
  logic [7:0]  g_addr;
  logic        g_rw;
  logic [1:0]  g_size;
  logic [31:0] g_wdata;
  exp_t        m_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_flight) lat++;
      if (ram_en && !en_prev) begin
        g_du = (ram_addr >= DU_BASE);
        if (req_prev == 2'b11) check("arb_rr_winner", 32'(g_du), 32'(rr_ptr));
        rr_ptr = !g_du;
        g_addr = ram_addr; g_rw = ram_rw; g_size = ram_size; g_wdata = ram_wdata;
        en_len = 0; lat = 0; in_flight = 1'b1; moc_prev = 1'b0;
      end
      if (ram_en) begin
        en_len++;
        check("ram_hold_ctl", 32'({ram_addr, ram_rw, ram_size}), 32'({g_addr, g_rw, g_size}));
        check("ram_hold_wdata", ram_wdata, g_wdata);
      end
      if (!ram_en && en_prev) check("ram_en_cycles", 32'(en_len), 32'(WAIT + 1));
      moc_w = g_du ? du_moc : if_moc;
      moc_l = g_du ? if_moc : du_moc;
      if (in_flight && moc_prev) check("moc_hold", 32'(moc_w), 32'(req_prev[g_du]));
      if (in_flight && moc_w && !moc_prev) begin
        check("moc_latency", 32'(lat), 32'(WAIT + 1));
        check("loser_moc", 32'(moc_l), 32'd0);
        check("ram_en_in_ack", 32'(ram_en), 32'd0);
        check("sb_pending", 32'((g_du ? q_du.size() : q_if.size()) != 0), 32'd1);
        if ((g_du ? q_du.size() : q_if.size()) != 0) begin
          if (g_du) m_e = q_du.pop_front();
          else      m_e = q_if.pop_front();
          check("ram_addr", 32'(g_addr), 32'(m_e.addr));
          check("ram_rw", 32'(g_rw), 32'(m_e.rw));
          check("ram_size", 32'(g_size), 32'(m_e.size));
          check("ram_wdata", g_wdata, m_e.wdata);
          check(g_du ? "du_rdata" : "if_rdata", g_du ? du_rdata : if_rdata, m_e.rdata);
        end
      end
      if (in_flight && moc_prev && !moc_w) in_flight = 1'b0;
      moc_prev = moc_w;
      en_prev  = ram_en;
    end
    req_prev = {du_mfa, if_mfa};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      model_mem[i] = ram_mem[i];
    end
    ram_mem[8'h10]   = 32'hE0846064;
    model_mem[8'h10] = 32'hE0846064;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_if_moc", 32'(if_moc), 32'd0);
    check("rst_du_moc", 32'(du_moc), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_du_rdata", du_rdata, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Simultaneous requests after reset: fetch wins; then a repeat pair.
    fork
      do_fetch(8'h10);
      do_data(1'b0, 2'b00, 8'h22, 32'h000000A5, 1'b0);
    join
    check("mem_byte_write", ram_mem[8'h22], model_mem[8'h22]);
    fork
      do_fetch(8'h11);
      do_data(1'b1, 2'b10, 8'h22, 32'h0, 1'b0);
    join
    do_data(1'b0, 2'b10, 8'h30, 32'hDEADBEEF, 1'b1);
    tick();
    check("mem_early_drop_write", ram_mem[8'h30], 32'hDEADBEEF);

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          do_fetch(8'($urandom_range(0, 31)));
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          repeat ($urandom_range(0, 3)) tick();
          do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(32, 255)), $urandom, $urandom_range(0, 5) == 0);
        end
      end
    join
    tick();
    check("sb_if_drained", 32'(q_if.size()), 32'd0);
    check("sb_du_drained", 32'(q_du.size()), 32'd0);

    // Zero-wait instance: one enable cycle, MOC on the following edge.
    if0_addr = 8'h05;
    if0_mfa  = 1'b1;
    tick();
    check("w0_en_first", 32'(ram0_en), 32'd1);
    check("w0_size", 32'(ram0_size), 32'd2);
    check("w0_moc_early", 32'(if0_moc), 32'd0);
    tick();
    check("w0_en_second", 32'(ram0_en), 32'd0);
    check("w0_moc", 32'(if0_moc), 32'd1);
    check("w0_rdata", if0_rdata, 32'hC0FFEE05);
    if0_mfa = 1'b0;
    tick();
    check("w0_moc_release", 32'(if0_moc), 32'd0);

    // Reset mid-access; afterwards a pending fetch wins despite the pointer.
    mon_en  = 1'b0;
    if_addr = 8'h03;
    if_mfa  = 1'b1;
    tick();
    check("pre_rst_fetch_grant", 32'(ram_en && ram_addr == 8'h03), 32'd1);
    du_addr = 8'h40; du_rw = 1'b1; du_size = 2'b10;
    du_mfa  = 1'b1;
    tick();
    check("pre_rst_in_access", 32'(ram_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_ram_en", 32'(ram_en), 32'd0);
    check("async_rst_if_moc", 32'(if_moc), 32'd0);
    check("async_rst_du_moc", 32'(du_moc), 32'd0);
    check("async_rst_if_rdata", if_rdata, 32'd0);
    check("async_rst_du_rdata", du_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_grant_en", 32'(ram_en), 32'd1);
    check("post_rst_grant_fetch", 32'(ram_addr), 32'h03);
    wait_moc(1'b0, 1'b1, "post_rst_if_moc");
    check("post_rst_if_rdata", if_rdata, model_mem[8'h03]);
    if_mfa = 1'b0;
    du_mfa = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
